// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one full-adder
// cell (a + ~b + 1) and a carry flop, one bit per clock, start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   diff_reg;
    logic             borrow_reg, overflow_reg;

    // Single full-adder cell fed with the current operand bits.
    logic bit_a, bit_nb, sum_bit, carry_next, last_bit;
    assign bit_a      = a_sh_reg[0];
    assign bit_nb     = ~b_sh_reg[0];
    assign sum_bit    = bit_a ^ bit_nb ^ carry_reg;
    assign carry_next = (bit_a & bit_nb) | (bit_a & carry_reg) | (bit_nb & carry_reg);
    assign last_bit   = (cnt_reg == LAST_BIT);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            res_sh_reg   <= '0;
            carry_reg    <= 1'b0;
            cnt_reg      <= '0;
            diff_reg     <= '0;
            borrow_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    res_sh_reg <= {sum_bit, res_sh_reg[WIDTH-1:1]};
                    carry_reg  <= carry_next;
                    cnt_reg    <= cnt_reg + 1'b1;
                    // On the MSB, carry_reg is the carry into the MSB and carry_next the carry out.
                    if (last_bit) begin
                        diff_reg     <= {bit_a ^ bit_nb ^ carry_next, sum_bit, res_sh_reg[WIDTH-1:1]};
                        borrow_reg   <= ~carry_next;
                        overflow_reg <= carry_reg ^ carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_reg == SHIFT);
    assign done     = (state_reg == DONE);
    assign diff     = diff_reg;
    assign borrow   = borrow_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: hand-computed results, latency, handshake and reset.
module tb_serial_subtractor;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow, overflow;
    logic [W:0]   diff;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Launches one operation and observes 16 post-edge samples starting after the accepting edge.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int busy_n, output int done_at, output int done_n, output int early_nz);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        busy_n = 0; done_at = -1; done_n = 0; early_nz = 0;
        for (int e = 0; e < 16; e++) begin
            if (e > 0) begin @(posedge clk); #1; end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = e;
            end else if (done_at < 0 && diff !== '0) begin
                early_nz++;
            end
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (diff !== 7'd0) begin errors++; $display("FAIL reset_diff got %b want 0", diff); end
        checks++; if (borrow !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags got b=%b o=%b want 0 0", borrow, overflow); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_no_start got busy=%b done=%b want 0 0", busy, done); end
        $display("reset: busy=%b done=%b diff=%b", busy, done, diff);
    endtask

    task automatic test_basic;
        int bn, da, dn, ez;
        run_op(6'd13, 6'd5, bn, da, dn, ez);
        checks++; if (bn != W) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", bn, W); end
        checks++; if (da != W) begin errors++; $display("FAIL basic_done_latency got %0d want %0d", da, W); end
        checks++; if (dn != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", dn); end
        checks++; if (diff !== 7'b0001000) begin errors++; $display("FAIL basic_diff got %b want 0001000", diff); end
        checks++; if (borrow !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL basic_flags got b=%b o=%b want 0 0", borrow, overflow); end
        $display("op 13-5: diff=%b borrow=%b overflow=%b done_at=%0d", diff, borrow, overflow, da);
    endtask

    task automatic test_negative;
        int bn, da, dn, ez;
        run_op(6'd5, 6'd13, bn, da, dn, ez);
        checks++; if (da != W || dn != 1) begin
            errors++; $display("FAIL neg_done got at=%0d n=%0d want %0d 1", da, dn, W); end
        checks++; if (diff !== 7'b1111000) begin errors++; $display("FAIL neg_diff got %b want 1111000", diff); end
        checks++; if (borrow !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL neg_flags got b=%b o=%b want 1 0", borrow, overflow); end
        $display("op 5-13: diff=%b borrow=%b overflow=%b", diff, borrow, overflow);
    endtask

    task automatic test_overflow;
        int bn, da, dn, ez;
        run_op(6'b011111, 6'b100000, bn, da, dn, ez);
        checks++; if (diff !== 7'b0111111) begin errors++; $display("FAIL ovf_diff got %b want 0111111", diff); end
        checks++; if (borrow !== 1'b1) begin errors++; $display("FAIL ovf_borrow got %b want 1", borrow); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_overflow got %b want 1", overflow); end
        $display("op 31-(-32): diff=%b borrow=%b overflow=%b", diff, borrow, overflow);
    endtask

    task automatic test_reset_mid_shift;
        int bn, da, dn, ez, idle_done;
        a = 6'd13; b = 6'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL async_rst_ctrl got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (diff !== 7'd0 || borrow !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL async_rst_out got diff=%b b=%b o=%b want 0 0 0", diff, borrow, overflow); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_done = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (done || busy) idle_done++;
        end
        checks++; if (idle_done != 0) begin errors++; $display("FAIL aborted_activity got %0d want 0", idle_done); end
        run_op(6'd5, 6'd13, bn, da, dn, ez);
        checks++; if (ez != 0) begin errors++; $display("FAIL pre_done_zero got %0d nonzero samples want 0", ez); end
        checks++; if (da != W || dn != 1) begin
            errors++; $display("FAIL post_rst_done got at=%0d n=%0d want %0d 1", da, dn, W); end
        checks++; if (diff !== 7'b1111000 || borrow !== 1'b1) begin
            errors++; $display("FAIL post_rst_result got diff=%b b=%b want 1111000 1", diff, borrow); end
        $display("reset mid-shift then 5-13: diff=%b borrow=%b", diff, borrow);
    endtask

    task automatic test_start_while_busy;
        int dn, bn, da, ez;
        a = 6'd13; b = 6'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dn = 0;
        for (int e = 0; e < 16; e++) begin
            if (e == 2) begin start = 1'b1; a = 6'd1; b = 6'd1; end
            if (e == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++; if (dn != 1) begin errors++; $display("FAIL busy_start_pulses got %0d want 1", dn); end
        checks++; if (diff !== 7'b0001000) begin errors++; $display("FAIL busy_start_diff got %b want 0001000", diff); end
        $display("op 13-5 with ignored start: diff=%b done_pulses=%0d", diff, dn);
        run_op(6'd0, 6'd0, bn, da, dn, ez);
        checks++; if (diff !== 7'd0 || borrow !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL zero_result got diff=%b b=%b o=%b want 0 0 0", diff, borrow, overflow); end
        $display("op 0-0: diff=%b borrow=%b overflow=%b", diff, borrow, overflow);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_negative;
        test_overflow;
        test_reset_mid_shift;
        test_start_while_busy;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
